// File: rtl/btb_pkg.sv
// Shared definitions for the fetch-side branch target buffer.
//   ENTRIES / INDEX_W / TAG_W : table geometry (direct-mapped, word-aligned PCs)
//   BR_NONE                   : branch-type encoding for "not a branch"
//   btb_entry_t               : one table entry {valid, tag, target[31:2]}
//   btb_index / btb_tag       : PC field extraction used by lookup and update
package btb_pkg;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned INDEX_W = 4;
    localparam int unsigned TAG_W   = 30 - INDEX_W;

    localparam logic [2:0] BR_NONE = 3'd0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [29:0]       target;
    } btb_entry_t;

    function automatic logic [INDEX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[INDEX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[31:INDEX_W+2];
    endfunction

endpackage

// File: rtl/btb_perf_cnt.sv
// Performance counters for the branch target buffer.
// Only elaborated when BTB_PERF_CNT_EN is defined; the default build leaves
// this file empty so no orphan module is left behind.
//   clk, rst    : clock, synchronous active-high reset (clears all counters)
//   lookup      : a non-stalled lookup happened this cycle
//   hit         : that lookup hit
//   update      : a table write was performed this cycle
//   lookup_cnt  : count of non-stalled lookups (wraps modulo 2^32)
//   hit_cnt     : count of non-stalled hits (wraps modulo 2^32)
//   update_cnt  : count of table writes (wraps modulo 2^32)
`ifdef BTB_PERF_CNT_EN
module btb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup,
    input  logic        hit,
    input  logic        update,
    output logic [31:0] lookup_cnt,
    output logic [31:0] hit_cnt,
    output logic [31:0] update_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt <= '0;
            hit_cnt    <= '0;
            update_cnt <= '0;
        end else begin
            if (lookup)
                lookup_cnt <= lookup_cnt + 32'd1;
            if (lookup && hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (update)
                update_cnt <= update_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/branch_target_buffer.sv
// Fetch-side branch target buffer: direct-mapped, flop-based table of taken
// branches. Lookup is combinational from registered state; updates come from
// the EX stage as branches resolve.
// Optional feature macro: BTB_PERF_CNT_EN (adds StallF and three counters).
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset; also forces lookup outputs low
//   PCF          : IF-stage PC to look up
//   BTBhit       : valid entry with matching tag at PCF's index
//   BTBtarget    : predicted target, zero on miss
//   EXpc         : PC of the branch resolving in EX
//   BrNPC        : resolved taken-target of that branch
//   BranchE      : EX branch resolved taken (writes the entry)
//   BranchTypeE  : EX branch type, BR_NONE when not a branch
//   Flush        : invalidate the whole table, dropping any same-cycle update
//   StallF       : IF stalled (perf build only)
//   LookupCnt / HitCnt / UpdateCnt : 32-bit counters (perf build only)
module branch_target_buffer
    import btb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        BTBhit,
    output logic [31:0] BTBtarget,
    input  logic [31:0] EXpc,
    input  logic [31:0] BrNPC,
    input  logic        BranchE,
    input  logic [2:0]  BranchTypeE,
    input  logic        Flush
`ifdef BTB_PERF_CNT_EN
    ,
    input  logic        StallF,
    output logic [31:0] LookupCnt,
    output logic [31:0] HitCnt,
    output logic [31:0] UpdateCnt
`endif
);

    btb_entry_t          table_q [ENTRIES];
    btb_entry_t          rd_entry;
    logic [INDEX_W-1:0]  wr_idx;
    logic                update_fire;

    // Direction is owned by the BHT, so BranchTypeE never changes the table;
    // word-offset bits of the PCs and target are not stored.
    logic unused_inputs;
    assign unused_inputs = ^{BranchTypeE, PCF[1:0], EXpc[1:0], BrNPC[1:0]};

    // Lookup: reads registered contents only, so a same-cycle update of the
    // same index is seen from the next cycle onward.
    always_comb begin
        rd_entry  = table_q[btb_index(PCF)];
        BTBhit    = 1'b0;
        BTBtarget = '0;
        if (!rst && rd_entry.valid && (rd_entry.tag == btb_tag(PCF))) begin
            BTBhit    = 1'b1;
            BTBtarget = {rd_entry.target, 2'b00};
        end
    end

    assign wr_idx      = btb_index(EXpc);
    assign update_fire = !rst && !Flush && BranchE;

    // Only valid bits are cleared; tag/target contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                table_q[i].valid <= 1'b0;
        end else if (BranchE) begin
            table_q[wr_idx] <= '{valid: 1'b1, tag: btb_tag(EXpc), target: BrNPC[31:2]};
        end
    end

`ifdef BTB_PERF_CNT_EN
    btb_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .lookup     (!StallF),
        .hit        (BTBhit),
        .update     (update_fire),
        .lookup_cnt (LookupCnt),
        .hit_cnt    (HitCnt),
        .update_cnt (UpdateCnt)
    );
`else
    logic unused_update;
    assign unused_update = update_fire;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a table of per-cycle vectors
// (inputs plus expected same-cycle lookup result) and hand-written sequences
// for the reset sweep and, in the perf build, the counters.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        BTBhit;
    logic [31:0] BTBtarget;
    logic [31:0] EXpc;
    logic [31:0] BrNPC;
    logic        BranchE;
    logic [2:0]  BranchTypeE;
    logic        Flush;
`ifdef BTB_PERF_CNT_EN
    logic        StallF;
    logic [31:0] LookupCnt;
    logic [31:0] HitCnt;
    logic [31:0] UpdateCnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .BTBhit      (BTBhit),
        .BTBtarget   (BTBtarget),
        .EXpc        (EXpc),
        .BrNPC       (BrNPC),
        .BranchE     (BranchE),
        .BranchTypeE (BranchTypeE),
        .Flush       (Flush)
`ifdef BTB_PERF_CNT_EN
        ,
        .StallF      (StallF),
        .LookupCnt   (LookupCnt),
        .HitCnt      (HitCnt),
        .UpdateCnt   (UpdateCnt)
`endif
    );

    // A taken branch must always carry a real branch type.
    always @(posedge clk) begin
        assert (!(BranchE && BranchTypeE == 3'd0))
            else $error("illegal BranchE with BranchTypeE=0");
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        br_e;
        logic [2:0]  br_type;
        logic [31:0] ex_pc;
        logic [31:0] npc;
        logic [31:0] pcf;
        logic        exp_hit;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; Flush = 1'b0; BranchE = 1'b0; BranchTypeE = 3'd0;
        EXpc = '0; BrNPC = '0; PCF = '0;
`ifdef BTB_PERF_CNT_EN
        StallF = 1'b1;
`endif
    endtask

    // Drive one cycle's inputs after the falling edge, check the same-cycle
    // lookup away from the rising edge.
    task automatic run_vec(input int n, input vec_t v);
        @(negedge clk);
        rst = v.rst; Flush = v.flush; BranchE = v.br_e; BranchTypeE = v.br_type;
        EXpc = v.ex_pc; BrNPC = v.npc; PCF = v.pcf;
        #2;
        check($sformatf("vec%0d_hit", n), {31'd0, BTBhit}, {31'd0, v.exp_hit});
        check($sformatf("vec%0d_target", n), BTBtarget, v.exp_tgt);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic exp_hit, input logic [31:0] exp_tgt);
        @(negedge clk);
        idle_inputs();
        PCF = pc;
        #2;
        check({name, "_hit"}, {31'd0, BTBhit}, {31'd0, exp_hit});
        check({name, "_target"}, BTBtarget, exp_tgt);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        //          rst   flush br_e  type  ex_pc          npc            pcf            hit   target
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0040, 32'h0000_0100, 32'h0000_0040, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b1, 32'h0000_0100};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0080, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'd2, 32'h0000_0080, 32'h0000_0200, 32'h0000_0040, 1'b1, 32'h0000_0100};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0080, 1'b1, 32'h0000_0200};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0040, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0040, 32'h0000_0999, 32'h0000_0040, 1'b1, 32'h0000_0100};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b1, 32'h0000_0100};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0040, 32'h0000_0500, 32'h0000_0040, 1'b1, 32'h0000_0100};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0044, 32'h0000_0300, 32'h0000_0044, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0044, 1'b1, 32'h0000_0300};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 3'd3, 32'h0000_0044, 32'h0000_0304, 32'h0000_0044, 1'b1, 32'h0000_0300};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0044, 1'b1, 32'h0000_0304};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_0048, 32'h0000_0400, 32'h0000_0044, 1'b1, 32'h0000_0304};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0044, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0048, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 3'd1, 32'hFFFF_FFFC, 32'hABCD_0003, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1, 32'hABCD_0000};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1, 32'hABCD_0000};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_0050, 32'h0000_0500, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         32'h0000_0050, 1'b0, 32'h0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 26; i++)
            run_vec(i, vecs[i]);

        // Reset sweep: fill every index, confirm hits, pulse rst, confirm empty.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            BranchE = 1'b1; BranchTypeE = 3'd2;
            EXpc = 32'h0000_1000 + 32'(i * 4);
            BrNPC = 32'h0000_2000 + 32'(i * 16);
        end
        for (int i = 0; i < 16; i++)
            lookup($sformatf("fill%0d", i), 32'h0000_1000 + 32'(i * 4), 1'b1,
                   32'h0000_2000 + 32'(i * 16));
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 16; i++)
            lookup($sformatf("swept%0d", i), 32'h0000_1000 + 32'(i * 4), 1'b0, 32'h0);

`ifdef BTB_PERF_CNT_EN
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        check("cnt_rst_lookup", LookupCnt, 32'd0);
        check("cnt_rst_hit", HitCnt, 32'd0);
        check("cnt_rst_update", UpdateCnt, 32'd0);
        @(negedge clk);
        idle_inputs();
        BranchE = 1'b1; BranchTypeE = 3'd1; EXpc = 32'h40; BrNPC = 32'h100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle_inputs();
            StallF = 1'b0;
            PCF = (k < 4) ? 32'h40 : 32'h80;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle_inputs();
            PCF = 32'h40;
        end
        @(negedge clk);
        idle_inputs();
        Flush = 1'b1; BranchE = 1'b1; BranchTypeE = 3'd1; EXpc = 32'h44; BrNPC = 32'h300;
        @(negedge clk);
        idle_inputs();
        #2;
        check("cnt_lookup", LookupCnt, 32'd10);
        check("cnt_hit", HitCnt, 32'd4);
        check("cnt_update", UpdateCnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
